// File: rtl/mmio_uart.sv
// mmio_uart: memory-mapped 8N1 UART on the peripheral bus, 16-byte register window at BASE.
// Latency: writes commit at the clock edge, reads are combinational; txd falls 2 cycles after a TXDATA write.
// Backpressure: none on the bus; a TXDATA write to a full FIFO is dropped and sets tx_ovf. Receiver built only with MMIO_UART_RX_EN.
module mmio_uart #(
  parameter logic [31:0] BASE        = 32'hC000_0000,
  parameter int          TX_DEPTH    = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] paddr,
  output logic [31:0] pread,
  input  logic [31:0] pwrite,
  input  logic        pread_req,
  input  logic        pwrite_req,
  input  logic [2:0]  psize,
  output logic        txd,
  input  logic        rxd
);
  localparam int AW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // Bus decode; byte lanes and access size are irrelevant, every access covers a whole register.
  logic       hit, wr_hit, rd_hit, txdata_wr, status_wr, div_wr;
  logic [1:0] sel;
  assign hit       = (paddr[31:4] == BASE[31:4]);
  assign sel       = paddr[3:2];
  assign wr_hit    = pwrite_req && hit;
  assign rd_hit    = pread_req && hit;
  assign txdata_wr = wr_hit && (sel == 2'd0);
  assign status_wr = wr_hit && (sel == 2'd2);
  assign div_wr    = wr_hit && (sel == 2'd3);

  logic [15:0] div_q, eff_div;
  assign eff_div = (div_q == 16'd0) ? 16'd1 : div_q;

  // TX FIFO with one extra pointer bit to tell full from empty.
  logic [7:0]  fifo_mem_q [TX_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_full, fifo_empty, push, pop;
  logic [7:0]  fifo_head;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = txdata_wr && !fifo_full;
  assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d, tx_ovf_q, tx_ovf_d, tx_busy;
  assign tx_busy = (tx_state_q != TX_IDLE);
  assign txd     = txd_q;

  // FIFO storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= pwrite[7:0];
  end

  // Bus-visible registers, FIFO pointers and TX state.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q      <= DEFAULT_DIV;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      tx_ovf_q   <= 1'b0;
    end else begin
      if (div_wr) div_q <= pwrite[15:0];
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      tx_ovf_q   <= tx_ovf_d;
    end
  end

  // TX next state: each state lasts eff_div clocks; STOP chains straight into START when more data waits.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    pop        = 1'b0;
    txd_d      = 1'b1;
    tx_ovf_d   = (tx_ovf_q && !(status_wr && pwrite[5])) || (txdata_wr && fifo_full);
    case (tx_state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          tx_shift_d = fifo_head;
          tx_cnt_d   = eff_div - 16'd1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        txd_d = 1'b0;
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = eff_div - 16'd1;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        txd_d = tx_shift_q[0];
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = eff_div - 16'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            tx_shift_d = fifo_head;
            tx_cnt_d   = eff_div - 16'd1;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  logic        rx_valid_bit, rx_ovr_bit;
  logic [31:0] rxdata_rd;

`ifdef MMIO_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e   rx_state_q, rx_state_d;
  logic        rx_s1_q, rx_s2_q, rx_s3_q, rx_done, rx_rd;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
  assign rx_rd        = rd_hit && (sel == 2'd1);
  assign rx_valid_bit = rx_valid_q;
  assign rx_ovr_bit   = rx_ovr_q;
  assign rxdata_rd    = {23'b0, rx_valid_q, rx_byte_q};

  // Input synchronizer (s1, s2) plus one history flop for falling-edge detection, and RX state.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  // RX next state: half-bit wait to mid-start, then sample every eff_div clocks; flags follow a finished frame.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_cnt_d   = eff_div >> 1;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (rx_s2_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_cnt_d   = eff_div - 16'd1;
            rx_bit_d   = 3'd0;
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = eff_div - 16'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          rx_done    = rx_s2_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q && !(status_wr && pwrite[4]);
    if (rx_done) begin
      if (rx_valid_q && !rx_rd) begin
        rx_ovr_d = 1'b1;
      end else begin
        rx_byte_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end
    end else if (rx_rd) begin
      rx_valid_d = 1'b0;
    end
  end
`else
  logic unused_rx;
  assign unused_rx    = rxd;
  assign rx_valid_bit = 1'b0;
  assign rx_ovr_bit   = 1'b0;
  assign rxdata_rd    = '0;
`endif

  logic unused_bus;
  assign unused_bus = ^{psize, paddr[1:0], pwrite[31:16]};

  // Read mux: zero unless a read strobe hits the window.
  always_comb begin
    pread = '0;
    if (rd_hit) begin
      case (sel)
        2'd1:    pread = rxdata_rd;
        2'd2:    pread = {26'b0, tx_ovf_q, rx_ovr_bit, rx_valid_bit, tx_busy, fifo_empty, fifo_full};
        2'd3:    pread = {16'b0, div_q};
        default: pread = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart.sv
// tb_mmio_uart: randomized bench for mmio_uart against a timeline model of the serial line.
// Latency: model predicts pop edges and frame windows from divisor and write times.
// Backpressure: model tracks FIFO occupancy to predict dropped writes and tx_ovf.
module tb_mmio_uart;
  localparam int DEPTH = 4;
  localparam logic [31:0] A_TX  = 32'hC000_0000;
  localparam logic [31:0] A_RX  = 32'hC000_0004;
  localparam logic [31:0] A_ST  = 32'hC000_0008;
  localparam logic [31:0] A_DIV = 32'hC000_000C;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] paddr, pread, pwrite;
  logic        pread_req, pwrite_req;
  logic [2:0]  psize;
  logic        txd, rxd;

  always #5 clock = ~clock;

  mmio_uart #(.BASE(32'hC000_0000), .TX_DEPTH(DEPTH), .DEFAULT_DIV(16'd434)) dut (
    .clock(clock), .reset(reset), .paddr(paddr), .pread(pread), .pwrite(pwrite),
    .pread_req(pread_req), .pwrite_req(pwrite_req), .psize(psize), .txd(txd), .rxd(rxd)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: byte queue, frame start edges with their divisor, and the edge the transmitter frees up.
  int          cyc = 0;
  logic [7:0]  mq[$];
  int          fs[$];
  int          fd[$];
  logic [7:0]  fb[$];
  int          next_free;
  int          md;
  logic [15:0] mdiv;
  logic        movf;
  logic [7:0]  tx_bytes [8];

  function automatic void model_reset();
    mq.delete(); fs.delete(); fd.delete(); fb.delete();
    next_free = 0; mdiv = 16'd434; md = 434; movf = 1'b0;
  endfunction

  function automatic void model_edge();
    logic hit;
    logic full_b;
    hit    = (paddr[31:4] == 28'hC00_0000);
    full_b = (mq.size() == DEPTH);
    if (mq.size() > 0 && cyc >= next_free) begin
      fs.push_back(cyc); fd.push_back(md); fb.push_back(mq.pop_front());
      next_free = cyc + 10 * md;
    end
    if (pwrite_req && hit) begin
      case (paddr[3:2])
        2'd0: if (full_b) movf = 1'b1; else mq.push_back(pwrite[7:0]);
        2'd2: if (pwrite[5]) movf = 1'b0;
        2'd3: begin mdiv = pwrite[15:0]; md = (mdiv == 16'd0) ? 1 : int'(mdiv); end
        default: ;
      endcase
    end
  endfunction

  // Serial level after edge c: frame from pop edge s occupies [s+1, s+1+10d), ten slots start/8 data/stop.
  function automatic logic exp_txd(input int c);
    int idx;
    foreach (fs[k]) begin
      if (c >= fs[k] + 1 && c < fs[k] + 1 + 10 * fd[k]) begin
        idx = (c - fs[k] - 1) / fd[k];
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return fb[k][idx-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    return {26'b0, movf, 2'b00, (cyc < next_free), (mq.size() == 0), (mq.size() == DEPTH)};
  endfunction

  task automatic bus(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
    pwrite_req = wr; pread_req = rd; paddr = a; pwrite = d;
    psize = 3'b001 << $urandom_range(0, 2);
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    if (reset) model_reset(); else model_edge();
    #1;
  endtask

  task automatic run_tx(input int n);
    for (int i = 0; i < n; i++) begin
      bus(1'b1, 1'b0, A_TX, {24'h0, tx_bytes[i]});
      step();
      chk("txd_wr", {31'b0, txd}, {31'b0, exp_txd(cyc)});
    end
    while (mq.size() > 0 || cyc < next_free + 2) begin
      bus(1'b0, 1'b1, A_ST, 32'h0);
      #1 chk("status", pread, exp_status());
      step();
      chk("txd", {31'b0, txd}, {31'b0, exp_txd(cyc)});
    end
  endtask

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    bus(1'b1, 1'b0, a, d);
    step();
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] mask, input logic [31:0] exp);
    bus(1'b0, 1'b1, a, 32'h0);
    #1 chk(tag, pread & mask, exp);
  endtask

`ifdef MMIO_UART_RX_EN
  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int d);
    bus(1'b0, 1'b0, A_TX, 32'h0);
    for (int k = 0; k < 10; k++) begin
      rxd = (k == 0) ? 1'b0 : (k == 9) ? stop_bit : b[k-1];
      repeat (d) step();
    end
    rxd = 1'b1;
    repeat (3 * d) step();
  endtask
`endif

  initial begin
    int n;
    logic [7:0] rb;
    reset = 1'b1; rxd = 1'b1;
    bus(1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();
    repeat (3) step();
    reset = 1'b0;

    chk("rst_txd", {31'b0, txd}, 32'h1);
    read_chk("rst_status", A_ST, 32'hFFFF_FFFF, 32'h2);
    read_chk("rst_div", A_DIV, 32'hFFFF_FFFF, 32'd434);
    read_chk("rd_txdata", A_TX, 32'hFFFF_FFFF, 32'h0);
    read_chk("rd_rxdata_rst", A_RX, 32'hFFFF_FFFF, 32'h0);
    read_chk("div_lowbits", 32'hC000_000F, 32'hFFFF_FFFF, 32'd434);
    read_chk("miss_rd", 32'hC000_0010, 32'hFFFF_FFFF, 32'h0);
    bus(1'b0, 1'b0, A_DIV, 32'h0);
    #1 chk("no_rd_req", pread, 32'h0);

    write_reg(A_DIV, 32'd4);
    read_chk("div_wr4", A_DIV, 32'hFFFF_FFFF, 32'd4);

    // Single 0x55 frame at div 4.
    tx_bytes[0] = 8'h55;
    run_tx(1);

    // Six back-to-back writes into a 4-deep FIFO: the sixth is dropped.
    for (int i = 0; i < 6; i++) tx_bytes[i] = 8'($urandom);
    run_tx(6);
    read_chk("ovf_set", A_ST, 32'h20, 32'h20);
    write_reg(A_ST, 32'h20);
    read_chk("ovf_clr", A_ST, 32'h20, 32'h0);

    // Random divisors (0 acts as 1) and burst lengths.
    for (int r = 0; r < 6; r++) begin
      write_reg(A_DIV, 32'($urandom_range(0, 5)));
      read_chk("div_rand", A_DIV, 32'hFFFF_FFFF, {16'h0, mdiv});
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) tx_bytes[i] = 8'($urandom);
      run_tx(n);
      read_chk("ovf_rand", A_ST, 32'h20, {26'b0, movf, 5'b0});
      write_reg(A_ST, 32'h20);
    end

    // Out-of-window and ignored writes change nothing.
    write_reg(32'hC000_0010, 32'h77);
    read_chk("miss_wr_tx", A_ST, 32'hFFFF_FFFF, 32'h2);
    write_reg(32'hC000_001C, 32'h99);
    read_chk("miss_wr_div", A_DIV, 32'hFFFF_FFFF, {16'h0, mdiv});
    write_reg(A_RX, 32'h1FF);
    read_chk("rx_wr_ign", A_ST, 32'hFFFF_FFFF, 32'h2);

    // Reset in the middle of a frame.
    write_reg(A_DIV, 32'd4);
    write_reg(A_TX, 32'hF0);
    bus(1'b0, 1'b0, A_TX, 32'h0);
    repeat (10) step();
    chk("mid_frame_low", {31'b0, txd}, {31'b0, exp_txd(cyc)});
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_txd", {31'b0, txd}, 32'h1);
    read_chk("rst_mid_status", A_ST, 32'hFFFF_FFFF, 32'h2);
    read_chk("rst_mid_div", A_DIV, 32'hFFFF_FFFF, 32'd434);
    bus(1'b0, 1'b0, A_TX, 32'h0);
    repeat (6) begin
      step();
      chk("rst_txd_idle", {31'b0, txd}, 32'h1);
    end

`ifdef MMIO_UART_RX_EN
    write_reg(A_DIV, 32'd4);
    send_rx(8'hA3, 1'b1, 4);
    read_chk("rx_valid", A_ST, 32'h18, 32'h08);
    read_chk("rx_a3_first", A_RX, 32'hFFFF_FFFF, 32'h1A3);
    step();
    read_chk("rx_a3_second", A_RX, 32'hFFFF_FFFF, 32'h0A3);
    step();
    send_rx(8'h11, 1'b1, 4);
    send_rx(8'h22, 1'b1, 4);
    read_chk("rx_ovr", A_ST, 32'h18, 32'h18);
    read_chk("rx_keep_first", A_RX, 32'hFFFF_FFFF, 32'h111);
    step();
    send_rx(8'h44, 1'b0, 4);
    read_chk("rx_frame_err_empty", A_RX, 32'hFFFF_FFFF, 32'h011);
    send_rx(8'h5A, 1'b1, 4);
    send_rx(8'h66, 1'b0, 4);
    read_chk("rx_frame_err_full", A_RX, 32'hFFFF_FFFF, 32'h15A);
    step();
    write_reg(A_ST, 32'h10);
    read_chk("rx_ovr_clr", A_ST, 32'h18, 32'h0);
    for (int r = 0; r < 4; r++) begin
      rb = 8'($urandom);
      send_rx(rb, 1'b1, 4);
      read_chk("rx_rand", A_RX, 32'hFFFF_FFFF, {23'b0, 1'b1, rb});
      step();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
